// File: rtl/issue_scheduler.sv
// Issue arbiter for four functional units sharing one result bus (CDB).
// It grants at most one head entry per cycle and books the bus slot the result will occupy.
module issue_scheduler #(
    parameter int INT_LAT  = 1,
    parameter int MEM_LAT  = 1,
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 6
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       int_issue_rdy,
    input  logic       mem_issue_rdy,
    input  logic       mult_issue_rdy,
    input  logic       div_issue_rdy,
    output logic       issue_done_int,
    output logic       issue_done_mem,
    output logic       issue_done_mult,
    output logic       issue_done_div,
    output logic [1:0] cdb_owner,
    output logic       cdb_owner_valid,
    output logic       div_busy
);

    // Each latency must lie in 1..15.
    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    localparam int MAXL = max4(INT_LAT, MEM_LAT, MULT_LAT, DIV_LAT);

    logic [MAXL:0] rsv;
    logic [1:0]    slot_owner [MAXL:0];
    logic [3:0]    div_cnt;
    logic          rr_mem;

    logic int_elig;
    logic mem_elig;
    logic mult_elig;
    logic div_elig;
    logic div_free;

    // The divider frees up on the edge that ends its last busy cycle, so a
    // successor may issue in the cycle the predecessor's result is on the bus.
    assign div_free  = (div_cnt <= 4'd1);
    assign int_elig  = int_issue_rdy  & ~rsv[INT_LAT];
    assign mem_elig  = mem_issue_rdy  & ~rsv[MEM_LAT];
    assign mult_elig = mult_issue_rdy & ~rsv[MULT_LAT];
    assign div_elig  = div_issue_rdy  & ~rsv[DIV_LAT] & div_free;

    always_comb begin
        issue_done_int  = 1'b0;
        issue_done_mem  = 1'b0;
        issue_done_mult = 1'b0;
        issue_done_div  = 1'b0;
        if (i_rst_n) begin
            if (div_elig) begin
                issue_done_div = 1'b1;
            end else if (mult_elig) begin
                issue_done_mult = 1'b1;
            end else if (int_elig && (!rr_mem || !mem_elig)) begin
                issue_done_int = 1'b1;
            end else if (mem_elig) begin
                issue_done_mem = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rsv     <= '0;
            div_cnt <= 4'd0;
            rr_mem  <= 1'b0;
            for (int k = 0; k <= MAXL; k++) begin
                slot_owner[k] <= 2'd0;
            end
        end else begin
            for (int k = 0; k < MAXL; k++) begin
                rsv[k]        <= rsv[k+1];
                slot_owner[k] <= slot_owner[k+1];
            end
            rsv[MAXL]        <= 1'b0;
            slot_owner[MAXL] <= 2'd0;

            // Slot L-1 after the shift is exactly L cycles after the grant cycle.
            if (issue_done_div) begin
                rsv[DIV_LAT-1]        <= 1'b1;
                slot_owner[DIV_LAT-1] <= 2'd3;
            end
            if (issue_done_mult) begin
                rsv[MULT_LAT-1]        <= 1'b1;
                slot_owner[MULT_LAT-1] <= 2'd2;
            end
            if (issue_done_int) begin
                rsv[INT_LAT-1]        <= 1'b1;
                slot_owner[INT_LAT-1] <= 2'd0;
            end
            if (issue_done_mem) begin
                rsv[MEM_LAT-1]        <= 1'b1;
                slot_owner[MEM_LAT-1] <= 2'd1;
            end

            if (issue_done_div) begin
                div_cnt <= 4'(DIV_LAT);
            end else if (div_cnt != 4'd0) begin
                div_cnt <= div_cnt - 4'd1;
            end

            if (issue_done_int) begin
                rr_mem <= 1'b1;
            end else if (issue_done_mem) begin
                rr_mem <= 1'b0;
            end
        end
    end

    assign cdb_owner_valid = rsv[0];
    assign cdb_owner       = slot_owner[0];
    assign div_busy        = (div_cnt != 4'd0);

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: grants, CDB ownership, divider occupancy and reset.
module tb_issue_scheduler;

    logic       clk;
    logic       rst_n;
    logic       int_rdy, mem_rdy, mult_rdy, div_rdy;
    logic       g_int, g_mem, g_mult, g_div;
    logic [1:0] owner;
    logic       owner_vld;
    logic       busy;

    int n_cmp;
    int n_bad;

    issue_scheduler dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .int_issue_rdy  (int_rdy),
        .mem_issue_rdy  (mem_rdy),
        .mult_issue_rdy (mult_rdy),
        .div_issue_rdy  (div_rdy),
        .issue_done_int (g_int),
        .issue_done_mem (g_mem),
        .issue_done_mult(g_mult),
        .issue_done_div (g_div),
        .cdb_owner      (owner),
        .cdb_owner_valid(owner_vld),
        .div_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle's inputs, then wait to the falling edge to sample.
    // rdy packing: {div, mult, mem, int}
    task automatic cyc(input logic rn, input logic [3:0] rdy);
        rst_n    = rn;
        div_rdy  = rdy[3];
        mult_rdy = rdy[2];
        mem_rdy  = rdy[1];
        int_rdy  = rdy[0];
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gnt();
        return {4'd0, g_div, g_mult, g_mem, g_int};
    endfunction

    function automatic logic [7:0] cdb();
        return {5'd0, owner_vld, owner};
    endfunction

    task automatic do_reset();
        cyc(1'b0, 4'b1111);
        check("rst_gnt_low", gnt(), 8'h00);
        tick();
        cyc(1'b0, 4'b0000);
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        {div_rdy, mult_rdy, mem_rdy, int_rdy} = 4'b0000;
        tick();

        // Reset state
        do_reset();
        cyc(1'b1, 4'b0000);
        check("post_rst_cdb", cdb(), 8'h00);
        check("post_rst_busy", {7'd0, busy}, 8'h00);
        tick();

        // Single int issue
        cyc(1'b1, 4'b0001);
        check("single_gnt", gnt(), 8'h01);
        tick();
        cyc(1'b1, 4'b0000);
        check("single_cdb", cdb(), 8'h04);
        check("single_idle_gnt", gnt(), 8'h00);
        tick();
        cyc(1'b1, 4'b0000);
        check("single_cdb_clear", cdb(), 8'h00);
        tick();

        // Mult occupies the slot int wants three cycles later
        cyc(1'b1, 4'b0100);
        check("coll_mult_gnt", gnt(), 8'h04);
        tick();
        cyc(1'b1, 4'b0000); tick();
        cyc(1'b1, 4'b0000); tick();
        cyc(1'b1, 4'b0001);
        check("coll_int_blocked", gnt(), 8'h00);
        tick();
        cyc(1'b1, 4'b0001);
        check("coll_int_gnt", gnt(), 8'h01);
        check("coll_cdb_mult", cdb(), 8'h06);
        tick();
        cyc(1'b1, 4'b0000);
        check("coll_cdb_int", cdb(), 8'h04);
        tick();

        // Priority from reset; each station drops rdy once granted
        do_reset();
        cyc(1'b1, 4'b1111);
        check("prio_div", gnt(), 8'h08);
        check("prio_busy_t0", {7'd0, busy}, 8'h00);
        tick();
        cyc(1'b1, 4'b0111);
        check("prio_mult", gnt(), 8'h04);
        check("prio_busy_t1", {7'd0, busy}, 8'h01);
        tick();
        cyc(1'b1, 4'b0011);
        check("prio_int", gnt(), 8'h01);
        tick();
        cyc(1'b1, 4'b0010);
        check("prio_mem", gnt(), 8'h02);
        check("prio_cdb_t3", cdb(), 8'h04);
        tick();
        cyc(1'b1, 4'b0000);
        check("prio_cdb_t4", cdb(), 8'h05);
        check("prio_busy_t4", {7'd0, busy}, 8'h01);
        tick();
        cyc(1'b1, 4'b0000);
        check("prio_cdb_t5", cdb(), 8'h06);
        tick();
        cyc(1'b1, 4'b0000);
        check("prio_cdb_t6", cdb(), 8'h07);
        check("prio_busy_t6", {7'd0, busy}, 8'h01);
        tick();
        cyc(1'b1, 4'b0000);
        check("prio_busy_t7", {7'd0, busy}, 8'h00);
        check("prio_cdb_t7", cdb(), 8'h00);
        tick();

        // Round-robin between int and mem from reset
        do_reset();
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, (k < 4) ? 4'b0011 : 4'b0000);
            if (k < 4) check($sformatf("rr_gnt%0d", k), gnt(), (k % 2 == 0) ? 8'h01 : 8'h02);
            if (k > 0) check($sformatf("rr_cdb%0d", k), cdb(), (k % 2 == 1) ? 8'h04 : 8'h05);
            tick();
        end

        // Divider back-to-back with rdy held
        for (int k = 0; k < 13; k++) begin
            cyc(1'b1, 4'b1000);
            check($sformatf("div_gnt%0d", k), gnt(), (k % 6 == 0) ? 8'h08 : 8'h00);
            if (k == 6 || k == 12) check($sformatf("div_cdb%0d", k), cdb(), 8'h07);
            tick();
        end
        for (int k = 0; k < 7; k++) begin
            cyc(1'b1, 4'b0000);
            tick();
        end
        cyc(1'b1, 4'b0000);
        check("div_drained_busy", {7'd0, busy}, 8'h00);
        tick();

        // Reset while a mult result is in flight
        cyc(1'b1, 4'b0100);
        check("mid_mult_gnt", gnt(), 8'h04);
        tick();
        cyc(1'b1, 4'b0000); tick();
        cyc(1'b0, 4'b1111);
        check("mid_rst_gnt", gnt(), 8'h00);
        tick();
        cyc(1'b1, 4'b0000);
        check("mid_cdb_t3", cdb(), 8'h00);
        tick();
        cyc(1'b1, 4'b0000);
        check("mid_cdb_t4", cdb(), 8'h00);
        check("mid_busy_t4", {7'd0, busy}, 8'h00);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
